// File: rtl/eth_mux_pkg.sv
// Shared types and helpers for the packet-atomic N:1 Ethernet stream mux.
package eth_mux_pkg;

  localparam int unsigned ARB_RR   = 0;
  localparam int unsigned ARB_PRIO = 1;

  // Beat fields are sized for the widest supported configuration; narrower
  // instances zero-fill the unused upper bits.
  localparam int unsigned ETH_DATA_W  = 512;
  localparam int unsigned ETH_EMPTY_W = 6;
  localparam int unsigned ETH_CHAN_W  = 4;

  typedef enum logic {
    ST_IDLE,
    ST_LOCK
  } mux_state_t;

  typedef struct packed {
    logic [ETH_DATA_W-1:0]  data;
    logic                   sop;
    logic                   eop;
    logic [ETH_EMPTY_W-1:0] empty;
    logic [ETH_CHAN_W-1:0]  chan;
  } eth_beat_t;

  // First set request at or after ptr. Requests above NUM_IN are always zero,
  // so wrapping at 16 gives the same winner as wrapping at NUM_IN.
  function automatic logic [3:0] rr_pick(input logic [15:0] req, input logic [3:0] ptr);
    logic [3:0] idx;
    logic [3:0] pick;
    logic       found;
    pick  = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < 16; i++) begin
      idx = ptr + 4'(i);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/eth_skid_buf.sv
// Two-entry valid/ready register slice; in_ready depends only on registered occupancy.
module eth_skid_buf #(
  parameter type T = logic [7:0]
) (
  input  logic clk,
  input  logic rst,
  input  T     in_beat,
  input  logic in_valid,
  output logic in_ready,
  output T     out_beat,
  output logic out_valid,
  input  logic out_ready
);

  T           mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;
  logic       push;
  logic       pop;

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign out_beat  = mem[rd_ptr];
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_beat;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/eth_pkt_arb_mux_n.sv
// Packet-atomic N:1 Ethernet stream mux: RR or strict-priority arbitration,
// orphan-beat drop, per-channel packet counters and a registered skid output.
module eth_pkt_arb_mux_n
  import eth_mux_pkg::*;
#(
  parameter int unsigned NUM_IN   = 5,
  parameter int unsigned DATA_W   = 512,
  parameter int unsigned EMPTY_W  = $clog2(DATA_W/8),
  parameter int unsigned ARB_MODE = ARB_RR,
  parameter int unsigned CNT_W    = 32,
  localparam int unsigned CHAN_W  = $clog2(NUM_IN)
) (
  input  logic                      Clk,
  input  logic                      Rst,
  input  logic [NUM_IN-1:0]         in_valid,
  input  logic [NUM_IN*DATA_W-1:0]  in_data,
  input  logic [NUM_IN-1:0]         in_sop,
  input  logic [NUM_IN-1:0]         in_eop,
  input  logic [NUM_IN*EMPTY_W-1:0] in_empty,
  output logic [NUM_IN-1:0]         in_ready,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_data,
  output logic                      out_sop,
  output logic                      out_eop,
  output logic [EMPTY_W-1:0]        out_empty,
  input  logic                      out_ready,
  input  logic                      out_almostfull,
  output logic [CHAN_W-1:0]         out_chan,
  output logic [NUM_IN*CNT_W-1:0]   pkt_cnt,
  output logic [CNT_W-1:0]          err_cnt
);

  mux_state_t         state, state_nxt;
  logic [CHAN_W-1:0]  gnt, gnt_nxt;
  logic [CHAN_W-1:0]  ptr, ptr_nxt;
  logic [CHAN_W-1:0]  sel;
  logic [CHAN_W-1:0]  pick;
  logic [NUM_IN-1:0]  cand;
  logic [NUM_IN-1:0]  in_ready_c;
  logic [15:0]        req16;
  logic               push;
  logic               pkt_inc;
  logic [CNT_W-1:0]   orphan_sum;
  logic [CNT_W-1:0]   err_q;
  logic [CNT_W-1:0]   cnt_q [NUM_IN];
  logic [DATA_W-1:0]  ch_data  [NUM_IN];
  logic [EMPTY_W-1:0] ch_empty [NUM_IN];
  eth_beat_t          push_beat;
  eth_beat_t          head;
  logic               skid_ready;
  logic               skid_valid;
  logic               head_unused;

  always_comb begin
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      ch_data[i]  = in_data[i*DATA_W +: DATA_W];
      ch_empty[i] = in_empty[i*EMPTY_W +: EMPTY_W];
    end
  end

  assign cand = in_valid & in_sop;

  always_comb begin
    logic found;
    found = 1'b0;
    req16 = '0;
    req16[NUM_IN-1:0] = cand;
    pick  = '0;
    if (ARB_MODE == ARB_PRIO) begin
      for (int unsigned i = 0; i < NUM_IN; i++) begin
        if (cand[i] && !found) begin
          pick  = CHAN_W'(i);
          found = 1'b1;
        end
      end
    end else begin
      pick = CHAN_W'(rr_pick(req16, 4'(ptr)));
    end
  end

  // A sop+eop beat accepted on the grant cycle never enters LOCK, so the
  // next packet can be arbitrated on the following cycle.
  always_comb begin
    state_nxt  = state;
    gnt_nxt    = gnt;
    ptr_nxt    = ptr;
    in_ready_c = '0;
    push       = 1'b0;
    sel        = gnt;
    pkt_inc    = 1'b0;
    orphan_sum = '0;
    case (state)
      ST_IDLE: begin
        for (int unsigned i = 0; i < NUM_IN; i++) begin
          if (in_valid[i] && !in_sop[i]) begin
            in_ready_c[i] = 1'b1;
            orphan_sum    = orphan_sum + 1'b1;
          end
        end
        if ((|cand) && !out_almostfull) begin
          sel     = pick;
          gnt_nxt = pick;
          if (ARB_MODE != ARB_PRIO)
            ptr_nxt = (pick == CHAN_W'(NUM_IN-1)) ? '0 : pick + 1'b1;
          in_ready_c[pick] = skid_ready;
          push             = skid_ready;
          if (push && in_eop[pick]) pkt_inc   = 1'b1;
          else                      state_nxt = ST_LOCK;
        end
      end
      ST_LOCK: begin
        in_ready_c[gnt] = skid_ready;
        push            = in_valid[gnt] && skid_ready;
        if (push && in_eop[gnt]) begin
          pkt_inc   = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (Rst) begin
      in_ready_c = '0;
      push       = 1'b0;
      pkt_inc    = 1'b0;
      orphan_sum = '0;
    end
  end

  assign in_ready = in_ready_c;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= ST_IDLE;
      gnt   <= '0;
      ptr   <= '0;
      err_q <= '0;
      for (int unsigned i = 0; i < NUM_IN; i++) cnt_q[i] <= '0;
    end else begin
      state <= state_nxt;
      gnt   <= gnt_nxt;
      ptr   <= ptr_nxt;
      err_q <= err_q + orphan_sum;
      if (pkt_inc) cnt_q[sel] <= cnt_q[sel] + 1'b1;
    end
  end

  always_comb begin
    push_beat                      = '0;
    push_beat.data[DATA_W-1:0]     = ch_data[sel];
    push_beat.sop                  = in_sop[sel];
    push_beat.eop                  = in_eop[sel];
    push_beat.empty[EMPTY_W-1:0]   = ch_empty[sel];
    push_beat.chan[CHAN_W-1:0]     = sel;
  end

  eth_skid_buf #(.T(eth_beat_t)) u_skid (
    .clk       (Clk),
    .rst       (Rst),
    .in_beat   (push_beat),
    .in_valid  (push),
    .in_ready  (skid_ready),
    .out_beat  (head),
    .out_valid (skid_valid),
    .out_ready (out_ready)
  );

  assign out_valid   = skid_valid;
  assign out_data    = head.data[DATA_W-1:0];
  assign out_sop     = head.sop;
  assign out_eop     = head.eop;
  assign out_empty   = head.empty[EMPTY_W-1:0];
  assign out_chan    = head.chan[CHAN_W-1:0];
  assign head_unused = ^head;
  assign err_cnt     = err_q;

  always_comb begin
    pkt_cnt = '0;
    for (int unsigned i = 0; i < NUM_IN; i++) pkt_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
  end

endmodule

// File: tb/tb_eth_pkt_arb_mux_n.sv
// Directed bench for eth_pkt_arb_mux_n: an RR instance and a PRIO instance.
module tb_eth_pkt_arb_mux_n;

  localparam int N  = 5;
  localparam int DW = 512;
  localparam int EW = 6;
  localparam int CW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N-1:0]    in_valid, in_sop, in_eop, in_ready;
  logic [N*DW-1:0] in_data;
  logic [N*EW-1:0] in_empty;
  logic            out_valid, out_sop, out_eop, out_ready, out_almostfull;
  logic [DW-1:0]   out_data;
  logic [EW-1:0]   out_empty;
  logic [2:0]      out_chan;
  logic [N*CW-1:0] pkt_cnt;
  logic [CW-1:0]   err_cnt;

  logic [N-1:0]    p_in_valid, p_in_sop, p_in_eop, p_in_ready;
  logic [N*DW-1:0] p_in_data;
  logic [N*EW-1:0] p_in_empty;
  logic            p_out_valid, p_out_sop, p_out_eop;
  logic [DW-1:0]   p_out_data;
  logic [EW-1:0]   p_out_empty;
  logic [2:0]      p_out_chan;
  logic [N*CW-1:0] p_pkt_cnt;
  logic [CW-1:0]   p_err_cnt;

  eth_pkt_arb_mux_n #(.NUM_IN(N), .DATA_W(DW), .ARB_MODE(0), .CNT_W(CW)) dut (
    .Clk(clk), .Rst(rst), .in_valid(in_valid), .in_data(in_data), .in_sop(in_sop),
    .in_eop(in_eop), .in_empty(in_empty), .in_ready(in_ready), .out_valid(out_valid),
    .out_data(out_data), .out_sop(out_sop), .out_eop(out_eop), .out_empty(out_empty),
    .out_ready(out_ready), .out_almostfull(out_almostfull), .out_chan(out_chan),
    .pkt_cnt(pkt_cnt), .err_cnt(err_cnt)
  );

  eth_pkt_arb_mux_n #(.NUM_IN(N), .DATA_W(DW), .ARB_MODE(1), .CNT_W(CW)) dut_prio (
    .Clk(clk), .Rst(rst), .in_valid(p_in_valid), .in_data(p_in_data), .in_sop(p_in_sop),
    .in_eop(p_in_eop), .in_empty(p_in_empty), .in_ready(p_in_ready), .out_valid(p_out_valid),
    .out_data(p_out_data), .out_sop(p_out_sop), .out_eop(p_out_eop), .out_empty(p_out_empty),
    .out_ready(1'b1), .out_almostfull(1'b0), .out_chan(p_out_chan),
    .pkt_cnt(p_pkt_cnt), .err_cnt(p_err_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  int          pk_left [N];
  int          beat    [N];
  int          plen    [N];
  int          pnum    [N];
  bit          orph    [N];
  logic [EW-1:0] emp_val [N];

  typedef struct {int chan; int word; bit sop; bit eop; int empty;} mon_t;
  mon_t mon_q[$];

  logic          last_ov, last_or;
  logic [31:0]   last_word;
  logic [N-1:0]  last_irdy, last_ivld;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pc(input int i);
    return pkt_cnt[i*CW +: CW];
  endfunction

  function automatic bit busy();
    bit b;
    b = out_valid;
    for (int i = 0; i < N; i++) if (pk_left[i] > 0 || orph[i]) b = 1'b1;
    return b;
  endfunction

  task automatic src_clear();
    for (int i = 0; i < N; i++) begin
      pk_left[i] = 0; beat[i] = 0; plen[i] = 1; pnum[i] = 0; orph[i] = 1'b0; emp_val[i] = '0;
    end
    mon_q.delete();
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      logic [DW-1:0] d;
      d = '0;
      if (orph[i]) begin
        in_valid[i] = 1'b1; in_sop[i] = 1'b0; in_eop[i] = 1'b0;
        d[31:0] = 32'hDEAD_0000 | 32'(i);
      end else if (pk_left[i] > 0) begin
        in_valid[i] = 1'b1;
        in_sop[i]   = (beat[i] == 0);
        in_eop[i]   = (beat[i] == plen[i] - 1);
        d[31:0]     = 32'((i << 16) | (pnum[i] << 8) | beat[i]);
      end else begin
        in_valid[i] = 1'b0; in_sop[i] = 1'b0; in_eop[i] = 1'b0;
      end
      in_data[i*DW +: DW]  = d;
      in_empty[i*EW +: EW] = emp_val[i];
    end
  endtask

  // One clock: drive at negedge, sample handshakes before the edge, advance sources after.
  task automatic step();
    logic [N-1:0] acc;
    mon_t m;
    drive_inputs();
    #2;
    last_ov = out_valid; last_or = out_ready; last_word = out_data[31:0];
    last_irdy = in_ready; last_ivld = in_valid;
    acc = in_valid & in_ready;
    if (out_valid && out_ready) begin
      m.chan = int'(out_chan); m.word = int'(out_data[31:0]);
      m.sop = out_sop; m.eop = out_eop; m.empty = int'(out_empty);
      mon_q.push_back(m);
    end
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) begin
      if (acc[i]) begin
        if (orph[i]) orph[i] = 1'b0;
        else begin
          beat[i]++;
          if (beat[i] == plen[i]) begin beat[i] = 0; pnum[i]++; pk_left[i]--; end
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic p_cycle(input logic [N-1:0] v, input logic [N-1:0] s, input logic [N-1:0] e,
                         input logic [31:0] w1, input logic [31:0] w3);
    p_in_valid = v; p_in_sop = s; p_in_eop = e;
    p_in_data  = '0;
    p_in_data[1*DW +: 32] = w1;
    p_in_data[3*DW +: 32] = w3;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cnt0, cnt1, cnt2, idx;
    bit seen_drop, stall_prev;
    logic [31:0] prev_word;

    rst = 1'b1;
    src_clear();
    out_ready = 1'b1; out_almostfull = 1'b0;
    in_valid = '1; in_sop = '1; in_eop = '0; in_data = '0; in_empty = '0;
    p_in_valid = '0; p_in_sop = '0; p_in_eop = '0; p_in_data = '0; p_in_empty = '0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_chan", out_chan, 0);
    chk("rst_pkt_cnt", pkt_cnt, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_p_out_valid", p_out_valid, 0);
    rst = 1'b0;
    in_valid = '0; in_sop = '0;

    // Strict priority: ch1 and ch3 sop together
    p_cycle(5'b01010, 5'b01010, 5'b00000, 32'hA0, 32'hB0);
    #2 chk("prio_c0_ready", p_in_ready, 5'b00010);
    @(posedge clk); #1;
    chk("prio_c0_chan", p_out_chan, 1); chk("prio_c0_sop", p_out_sop, 1);
    chk("prio_c0_data", p_out_data[31:0], 32'hA0);
    @(negedge clk);
    p_cycle(5'b01010, 5'b01000, 5'b00010, 32'hA1, 32'hB0);
    #2 chk("prio_c1_ready", p_in_ready, 5'b00010);
    @(posedge clk); #1;
    chk("prio_c1_chan", p_out_chan, 1); chk("prio_c1_eop", p_out_eop, 1);
    chk("prio_c1_data", p_out_data[31:0], 32'hA1);
    @(negedge clk);
    p_cycle(5'b01000, 5'b01000, 5'b00000, 32'h0, 32'hB0);
    #2 chk("prio_c2_ready", p_in_ready, 5'b01000);
    @(posedge clk); #1;
    chk("prio_c2_chan", p_out_chan, 3); chk("prio_c2_sop", p_out_sop, 1);
    chk("prio_c2_data", p_out_data[31:0], 32'hB0);
    @(negedge clk);
    p_cycle(5'b01000, 5'b00000, 5'b01000, 32'h0, 32'hB1);
    #2 chk("prio_c3_ready", p_in_ready, 5'b01000);
    @(posedge clk); #1;
    chk("prio_c3_chan", p_out_chan, 3); chk("prio_c3_eop", p_out_eop, 1);
    @(negedge clk);
    p_cycle(5'b00000, 5'b00000, 5'b00000, 32'h0, 32'h0);
    @(negedge clk);
    chk("prio_pkt1", p_pkt_cnt[1*CW +: CW], 1);
    chk("prio_pkt3", p_pkt_cnt[3*CW +: CW], 1);

    // Round-robin: every channel sends two 3-beat packets
    src_clear();
    for (int i = 0; i < N; i++) begin pk_left[i] = 2; plen[i] = 3; end
    for (int c = 0; c < 300 && busy(); c++) step();
    chk("rr_done", busy(), 0);
    chk("rr_beats", mon_q.size(), 30);
    for (int k = 0; k < 10; k++) begin
      for (int b = 0; b < 3; b++) begin
        idx = k*3 + b;
        if (idx < mon_q.size()) begin
          chk("rr_chan", mon_q[idx].chan, k % 5);
          chk("rr_word", mon_q[idx].word, ((k % 5) << 16) | ((k / 5) << 8) | b);
          chk("rr_flags", {mon_q[idx].sop, mon_q[idx].eop}, {b == 0, b == 2});
        end
      end
    end
    for (int i = 0; i < N; i++) chk("rr_pkt_cnt", pc(i), 2);

    // Almost-full raised mid-packet: packet completes, next grant held off
    src_clear();
    pk_left[0] = 1; plen[0] = 8;
    pk_left[1] = 1; plen[1] = 2;
    repeat (2) step();
    out_almostfull = 1'b1;
    for (int c = 0; c < 50 && pk_left[0] > 0; c++) step();
    repeat (5) step();
    cnt0 = 0; cnt1 = 0;
    foreach (mon_q[j]) begin
      if (mon_q[j].chan == 0) begin
        chk("af_ch0_order", mon_q[j].word & 32'hFF, cnt0);
        cnt0++;
      end
      if (mon_q[j].chan == 1) cnt1++;
    end
    chk("af_ch0_beats", cnt0, 8);
    chk("af_ch1_held", cnt1, 0);
    chk("af_ch1_ready", last_irdy[1], 0);
    out_almostfull = 1'b0;
    for (int c = 0; c < 50 && busy(); c++) step();
    cnt1 = 0;
    foreach (mon_q[j]) if (mon_q[j].chan == 1) cnt1++;
    chk("af_ch1_beats", cnt1, 2);
    chk("af_pkt0", pc(0), 3);
    chk("af_pkt1", pc(1), 3);

    // Downstream stalls with out_ready pattern 1,0,0,1
    src_clear();
    pk_left[2] = 1; plen[2] = 6;
    seen_drop = 1'b0; stall_prev = 1'b0; prev_word = '0;
    for (int c = 0; c < 80 && busy(); c++) begin
      out_ready = (c % 4 == 0) || (c % 4 == 3);
      step();
      if (stall_prev) chk("stall_stable", last_word, prev_word);
      stall_prev = last_ov && !last_or;
      prev_word  = last_word;
      if (last_ivld[2] && !last_irdy[2]) seen_drop = 1'b1;
    end
    out_ready = 1'b1;
    chk("stall_done", busy(), 0);
    chk("stall_in_ready_drop", seen_drop, 1);
    chk("stall_beats", mon_q.size(), 6);
    foreach (mon_q[j]) chk("stall_word", mon_q[j].word, (2 << 16) | j);
    chk("stall_pkt2", pc(2), 3);

    // Single-beat packets with empty=17 on ch2
    src_clear();
    pk_left[2] = 4; plen[2] = 1; emp_val[2] = 6'd17;
    for (int c = 0; c < 40 && busy(); c++) step();
    chk("single_beats", mon_q.size(), 4);
    foreach (mon_q[j]) begin
      chk("single_empty", mon_q[j].empty, 17);
      chk("single_sop_eop", {mon_q[j].sop, mon_q[j].eop}, 2'b11);
    end
    chk("single_pkt2", pc(2), 7);

    // Orphan beat on ch4 while idle
    src_clear();
    orph[4] = 1'b1;
    step();
    chk("orphan_accepted", orph[4], 0);
    repeat (2) step();
    chk("orphan_err_cnt", err_cnt, 1);
    chk("orphan_no_out", mon_q.size(), 0);

    // Reset in the middle of a stalled packet from ch3
    src_clear();
    pk_left[3] = 1; plen[3] = 4;
    out_ready = 1'b0;
    repeat (2) step();
    chk("midrst_pre_valid", out_valid, 1);
    chk("midrst_pre_chan", out_chan, 3);
    rst = 1'b1;
    in_valid = '1; in_sop = '1;
    #2 chk("midrst_in_ready", in_ready, 0);
    @(posedge clk); #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_sop", out_sop, 0);
    chk("midrst_out_eop", out_eop, 0);
    chk("midrst_out_empty", out_empty, 0);
    chk("midrst_out_chan", out_chan, 0);
    chk("midrst_pkt_cnt", pkt_cnt, 0);
    chk("midrst_err_cnt", err_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    src_clear();
    in_valid = '0; in_sop = '0;
    out_ready = 1'b1;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
